mem_copy_engine: RTL
====================

Name: mem_copy_engine

Overview:
- Bus initiator for the single-port synchronous instruction/data memory. It drives the memory's address, write-enable and write-data pins and consumes its registered read data.
- On a start command it copies a block of LENGTH words from a source address to a destination address, one word at a time: a read cycle followed by a write cycle.
- It sits between the control/test logic and the memory. It is used to relocate program images after the memory loads its image during reset.

Parameters:
WIDTH, 32, data word width; must match the memory data width
ADDRSIZE, 12, memory address width; the memory holds 2^ADDRSIZE words

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  copy request; sampled only in IDLE
src_addr  input  ADDRSIZE  first source word address; captured on accepted start
dst_addr  input  ADDRSIZE  first destination word address; captured on accepted start
length  input  ADDRSIZE+1  number of words, 0..2^ADDRSIZE; captured on accepted start
busy  output  1  high from the cycle after an accepted start through the last write cycle
done  output  1  one-cycle pulse when a copy completes
mem_address  output  ADDRSIZE  to memory address
mem_wr  output  1  to memory wr
mem_dataIn  output  WIDTH  to memory dataIn
mem_dataOut  input  WIDTH  from memory dataOut; registered, 1-cycle read latency, held during write cycles

Behaviour:
- Reset is synchronous and active-high (already decided).
  - Reset wins over everything, including start.
  - Next state is IDLE; all captured registers and counters clear.
  - Output values under reset: busy=0, done=0, mem_wr=0, mem_address=0, mem_dataIn=0.
  - While reset is high the memory loads its image; the engine issues no access.
- States: IDLE, RD, WR, DONE.
- IDLE: outputs at their reset values.
  - start=1: capture src/dst/length and clear word counter i.
  - Go to DONE if length==0, else go to RD.
- RD: mem_address=src+i, mem_wr=0, busy=1. Next state is WR. The memory registers MEM[src+i] onto mem_dataOut at the end of this cycle.
- WR: mem_address=dst+i, mem_wr=1, mem_dataIn=mem_dataOut, passed straight through with no extra register, busy=1.
  - Increment i.
  - If i+1==length, go to DONE; else go to RD.
- DONE: done=1, busy=0, mem_wr=0. Next state is IDLE unconditionally. start in this cycle is ignored.
- Timing: start accepted at the edge ending cycle 0.
  - Word k is read in cycle 1+2k and written in cycle 2+2k.
  - done is high in cycle 2N+1 for N>0, and in cycle 1 for N=0.
  - A new start can be accepted in the cycle after done, i.e. from cycle 2N+2.
- start while not in IDLE is ignored and is not queued.
- Address arithmetic is modulo 2^ADDRSIZE: src+i and dst+i truncate to ADDRSIZE bits, so copies wrap past the top word.
- length=2^ADDRSIZE copies the whole memory; i is ADDRSIZE+1 bits wide.
- The copy runs forward in ascending i, with no overlap detection. If dst lies within (src, src+length), already-written words are re-read, giving a replication smear. This is defined behaviour.
- mem_wr is asserted only in WR. The memory's dataOut is never sampled outside the WR state.
- Reset during RD or WR aborts the copy.
  - Words already written stay written; no done pulse is produced.
  - mem_wr=0 from the first reset cycle.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=0, RD=1, WR=2, DONE=3);
  - default WIDTH and ADDRSIZE constants, shared with the memory.
- No sub-module is needed. The FSM, captured registers and counter fit in one module of roughly 150 lines.

Test Plan:
- Memory preloaded with 0x11,0x22,0x33,0x44 at 0x010..0x013; start src=0x010 dst=0x100 len=4 -> 0x100..0x103 = 0x11,0x22,0x33,0x44; done high in cycle 9 only; busy high in cycles 1-8; exactly 4 cycles have mem_wr=1.
- len=0, src=0x005, dst=0x006 -> done in cycle 1; mem_wr never asserted; memory unchanged.
- src=0xFFE dst=0x200 len=4, memory 0xFFE..0x001 = A,B,C,D -> 0x200..0x203 = A,B,C,D; RD addresses are 0xFFE, 0xFFF, 0x000, 0x001.
- Overlap: 0x020..0x022 = 7,8,9; src=0x020 dst=0x021 len=3 -> 0x021..0x023 = 7,7,7; 0x020 stays 7.
- Second start (src=0x300) pulsed in cycle 3 of a len=4 copy -> ignored; only the original copy happens; a single done pulse.
- reset asserted in cycle 4 of a len=4 copy (0x010->0x100) -> 0x100 written, 0x101..0x103 untouched; busy=0 and mem_wr=0 from cycle 4; no done pulse; a new start after reset runs normally.

Source files
------------

// File: rtl/mem_copy_engine_pkg.sv
// mem_copy_engine_pkg
//   Shared definitions for the memory copy engine and the memory it drives.
//   - state_t      : copy FSM state encoding (IDLE=0, RD=1, WR=2, DONE=3)
//   - DEF_WIDTH    : default memory data word width
//   - DEF_ADDRSIZE : default memory address width (memory holds 2^DEF_ADDRSIZE words)
package mem_copy_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_ADDRSIZE = 12;

endpackage

// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Bus initiator that copies a block of words inside a single-port synchronous
//   memory, one word per read cycle + write cycle, in ascending address order.
//
//   Handshake: start is only looked at in IDLE; a high start there is accepted
//   at that clock edge. busy is high from the following cycle through the last
//   write cycle, then done pulses for exactly one cycle and the engine returns
//   to IDLE. start at any other time is dropped, not queued.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   reset        : synchronous, active-high; also forces all outputs low
//   start        : copy request (IDLE only)
//   src_addr     : first source word address, captured on accepted start
//   dst_addr     : first destination word address, captured on accepted start
//   length       : word count 0..2^ADDRSIZE, captured on accepted start
//   busy         : copy in progress (RD/WR states)
//   done         : one-cycle completion pulse
//   mem_address  : memory address
//   mem_wr       : memory write enable (WR state only)
//   mem_dataIn   : memory write data
//   mem_dataOut  : memory registered read data (1-cycle latency)
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ADDRSIZE = DEF_ADDRSIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDRSIZE-1:0] src_addr,
    input  logic [ADDRSIZE-1:0] dst_addr,
    input  logic [ADDRSIZE:0]   length,
    output logic                busy,
    output logic                done,
    output logic [ADDRSIZE-1:0] mem_address,
    output logic                mem_wr,
    output logic [WIDTH-1:0]    mem_dataIn,
    input  logic [WIDTH-1:0]    mem_dataOut
);

    localparam logic [ADDRSIZE:0] CNT_ONE  = {{ADDRSIZE{1'b0}}, 1'b1};
    localparam logic [ADDRSIZE:0] CNT_ZERO = '0;

    state_t              state;
    state_t              state_next;
    logic [ADDRSIZE-1:0] src_q;
    logic [ADDRSIZE-1:0] dst_q;
    logic [ADDRSIZE:0]   len_q;
    // One bit wider than the address so a full-memory copy can count to 2^ADDRSIZE.
    logic [ADDRSIZE:0]   cnt_q;
    logic [ADDRSIZE:0]   cnt_inc;
    logic [ADDRSIZE-1:0] rd_addr;
    logic [ADDRSIZE-1:0] wr_addr;

    assign cnt_inc = cnt_q + CNT_ONE;
    // Address sums truncate to ADDRSIZE bits, so copies wrap past the top word.
    assign rd_addr = src_q + cnt_q[ADDRSIZE-1:0];
    assign wr_addr = dst_q + cnt_q[ADDRSIZE-1:0];

    // State register, captured operands and word counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && start) begin
                src_q <= src_addr;
                dst_q <= dst_addr;
                len_q <= length;
                cnt_q <= '0;
            end else if (state == ST_WR) begin
                cnt_q <= cnt_inc;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (length == CNT_ZERO) ? ST_DONE : ST_RD;
                end
            end
            ST_RD:   state_next = ST_WR;
            ST_WR:   state_next = (cnt_inc == len_q) ? ST_DONE : ST_RD;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs. Reset gates them combinationally so an aborted copy stops
    // writing in the very first reset cycle, not one cycle later.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        mem_wr      = 1'b0;
        mem_address = '0;
        mem_dataIn  = '0;
        if (!reset) begin
            case (state)
                ST_RD: begin
                    busy        = 1'b1;
                    mem_address = rd_addr;
                end
                ST_WR: begin
                    busy        = 1'b1;
                    mem_wr      = 1'b1;
                    mem_address = wr_addr;
                    // Read data registered by the memory at the end of RD is
                    // held during WR and forwarded without another register.
                    mem_dataIn  = mem_dataOut;
                end
                ST_DONE: begin
                    done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
